// File: rtl/data_mem_responder_pkg.sv
// Shared decode constants and select type for the data-memory responder.
package data_mem_responder_pkg;

  localparam int MMIO_BASE_BIT = 31;

  localparam logic [7:0] MMIO_CONSOLE = 8'h00;
  localparam logic [7:0] MMIO_CYCLE   = 8'h04;
  localparam logic [7:0] MMIO_TOHOST  = 8'h08;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_CONSOLE,
    SEL_CYCLE,
    SEL_TOHOST,
    SEL_NONE
  } dmem_sel_enum;

  // Word offset only: the two byte-lane bits never take part in decode.
  function automatic dmem_sel_enum decode_sel(input logic mmio, input logic [5:0] word_off);
    if (!mmio) return SEL_RAM;
    if (word_off == MMIO_CONSOLE[7:2]) return SEL_CONSOLE;
    if (word_off == MMIO_CYCLE[7:2]) return SEL_CYCLE;
    if (word_off == MMIO_TOHOST[7:2]) return SEL_TOHOST;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-responder data-memory bus; the core is master, the responder is slave.
interface data_mem_responder_if;
  logic        data_mem_write_enable;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_write_data;
  logic [31:0] data_mem_read_data;

  modport master (
    output data_mem_write_enable, data_mem_addr, data_mem_write_data,
    input  data_mem_read_data
  );

  modport slave (
    input  data_mem_write_enable, data_mem_addr, data_mem_write_data,
    output data_mem_read_data
  );
endinterface

// File: rtl/data_mem_responder_console_fifo.sv
// Console byte FIFO with valid/ready drain, occupancy count and sticky overflow.
module data_mem_responder_console_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign valid   = !empty;
  assign data    = empty ? '0 : mem[rd_ptr];
  assign do_pop  = valid && ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus console/cycle/tohost MMIO window.
// Build option DMEM_CYCLE_COUNTER_EN implements the cycle counter; otherwise CYCLE reads 0.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  dmem,
  output logic                 console_valid,
  output logic [7:0]           console_data,
  input  logic                 console_ready,
  output logic                 halt,
  output logic [31:0]          tohost_value
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  dmem_sel_enum  sel;
  logic          wr_en;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_overflow;
  logic [31:0]   console_status;
  logic [31:0]   cycle_value;
  logic          unused_addr;

  assign sel         = decode_sel(dmem.data_mem_addr[MMIO_BASE_BIT], dmem.data_mem_addr[7:2]);
  assign ram_idx     = dmem.data_mem_addr[AW+1:2];
  assign wr_en       = dmem.data_mem_write_enable && !halt && !reset;
  assign unused_addr = ^{dmem.data_mem_addr};

  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM) ram[ram_idx] <= dmem.data_mem_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt         <= 1'b0;
      tohost_value <= '0;
    end else if (wr_en && sel == SEL_TOHOST) begin
      halt         <= 1'b1;
      tohost_value <= dmem.data_mem_write_data;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  // A software load of the counter wins over the free-running increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (!halt) begin
      if (wr_en && sel == SEL_CYCLE) cycle_cnt <= dmem.data_mem_write_data;
      else cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_value = cycle_cnt;
`else
  assign cycle_value = '0;
`endif

  data_mem_responder_console_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_console_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en && sel == SEL_CONSOLE),
    .push_data (dmem.data_mem_write_data[7:0]),
    .valid     (console_valid),
    .data      (console_data),
    .ready     (console_ready),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  assign console_status = {16'b0, 8'(fifo_count), 5'b0, fifo_overflow, fifo_full, fifo_empty};

  always_comb begin
    dmem.data_mem_read_data = '0;
    case (sel)
      SEL_RAM:     dmem.data_mem_read_data = ram[ram_idx];
      SEL_CONSOLE: dmem.data_mem_read_data = console_status;
      SEL_CYCLE:   dmem.data_mem_read_data = cycle_value;
      SEL_TOHOST:  dmem.data_mem_read_data = tohost_value;
      default:     dmem.data_mem_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (MEM_WORDS=64, FIFO_DEPTH=4).
module tb_data_mem_responder;

  localparam logic [31:0] CONSOLE_A = 32'h8000_0000;
  localparam logic [31:0] CYCLE_A   = 32'h8000_0004;
  localparam logic [31:0] TOHOST_A  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        console_ready = 1'b0;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        halt;
  logic [31:0] tohost_value;
  int          checks = 0;
  int          errors = 0;

  data_mem_responder_if dmem();

  data_mem_responder #(.MEM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .dmem          (dmem),
    .console_valid (console_valid),
    .console_data  (console_data),
    .console_ready (console_ready),
    .halt          (halt),
    .tohost_value  (tohost_value)
  );

  always #5 clk = ~clk;

  // Inputs change just after a falling edge; each store occupies exactly one cycle.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    dmem.data_mem_write_enable = 1'b1;
    dmem.data_mem_addr = a;
    dmem.data_mem_write_data = d;
    @(negedge clk);
    dmem.data_mem_write_enable = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    dmem.data_mem_addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dmem.data_mem_write_enable = 1'b0;
    dmem.data_mem_addr = '0;
    dmem.data_mem_write_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %0b want 0", halt); end
    checks++; if (tohost_value !== 32'h0) begin errors++; $display("FAIL reset_tohost got %h want 0", tohost_value); end
    checks++; if (console_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", console_valid); end
    checks++; if (console_data !== 8'h00) begin errors++; $display("FAIL reset_cdata got %h want 00", console_data); end
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h1) begin errors++; $display("FAIL reset_status got %h want 00000001", dmem.data_mem_read_data); end
    set_addr(CYCLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h want 0", dmem.data_mem_read_data); end
  endtask

  task automatic test_ram();
    do_store(32'h10, 32'hDEADBEEF);
    set_addr(32'h10);
    checks++; if (dmem.data_mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_load got %h want deadbeef", dmem.data_mem_read_data); end
    set_addr(32'h110);
    checks++; if (dmem.data_mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_wrap got %h want deadbeef", dmem.data_mem_read_data); end
    do_store(32'h14, 32'h12345678);
    set_addr(32'h17);
    checks++; if (dmem.data_mem_read_data !== 32'h12345678) begin errors++; $display("FAIL ram_lowbits got %h want 12345678", dmem.data_mem_read_data); end
    set_addr(32'h10);
    checks++; if (dmem.data_mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_neighbor got %h want deadbeef", dmem.data_mem_read_data); end
    do_store(32'h20, 32'h11111111);
    set_addr(32'h20);
    checks++; if (dmem.data_mem_read_data !== 32'h11111111) begin errors++; $display("FAIL ram_0x20 got %h want 11111111", dmem.data_mem_read_data); end
    do_store(32'h8000_000C, 32'hFFFF_FFFF);
    set_addr(32'h8000_000C);
    checks++; if (dmem.data_mem_read_data !== 32'h0) begin errors++; $display("FAIL mmio_unmapped got %h want 0", dmem.data_mem_read_data); end
  endtask

  task automatic test_console();
    logic [7:0] exp_b [3];
    exp_b = '{8'h41, 8'h42, 8'h43};
    console_ready = 1'b0;
    #1;
    checks++; if (console_valid !== 1'b0) begin errors++; $display("FAIL con_pre_valid got %0b want 0", console_valid); end
    do_store(CONSOLE_A, 32'h41);
    #1;
    checks++; if (console_valid !== 1'b1 || console_data !== 8'h41) begin errors++; $display("FAIL con_first got v=%0b d=%h want v=1 d=41", console_valid, console_data); end
    do_store(CONSOLE_A, 32'h42);
    do_store(CONSOLE_A, 32'h43);
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0300) begin errors++; $display("FAIL con_status3 got %h want 00000300", dmem.data_mem_read_data); end
    console_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (console_valid !== 1'b1 || console_data !== exp_b[i]) begin errors++; $display("FAIL con_drain%0d got v=%0b d=%h want v=1 d=%h", i, console_valid, console_data, exp_b[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (console_valid !== 1'b0) begin errors++; $display("FAIL con_empty got %0b want 0", console_valid); end
    console_ready = 1'b0;
  endtask

  task automatic test_overflow();
    console_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_store(CONSOLE_A, 32'h10 + i);
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0406) begin errors++; $display("FAIL ovf_status got %h want 00000406", dmem.data_mem_read_data); end
    console_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (console_valid !== 1'b1 || console_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL ovf_drain%0d got v=%0b d=%h want v=1 d=%h", i, console_valid, console_data, 8'(8'h10 + i)); end
      @(negedge clk);
    end
    console_ready = 1'b0;
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0005) begin errors++; $display("FAIL ovf_sticky got %h want 00000005", dmem.data_mem_read_data); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [4];
    exp_b = '{8'h21, 8'h22, 8'h23, 8'h55};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) do_store(CONSOLE_A, 32'h20 + i);
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0402) begin errors++; $display("FAIL fpp_full got %h want 00000402", dmem.data_mem_read_data); end
    console_ready = 1'b1;
    dmem.data_mem_write_enable = 1'b1;
    dmem.data_mem_write_data = 32'h55;
    #1;
    checks++; if (console_data !== 8'h20) begin errors++; $display("FAIL fpp_head got %h want 20", console_data); end
    @(negedge clk);
    dmem.data_mem_write_enable = 1'b0;
    console_ready = 1'b0;
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0402) begin errors++; $display("FAIL fpp_after got %h want 00000402", dmem.data_mem_read_data); end
    console_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (console_valid !== 1'b1 || console_data !== exp_b[i]) begin errors++; $display("FAIL fpp_drain%0d got v=%0b d=%h want v=1 d=%h", i, console_valid, console_data, exp_b[i]); end
      @(negedge clk);
    end
    console_ready = 1'b0;
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0001) begin errors++; $display("FAIL fpp_end got %h want 00000001", dmem.data_mem_read_data); end
  endtask

  task automatic test_cycle();
`ifdef DMEM_CYCLE_COUNTER_EN
    do_store(CYCLE_A, 32'h64);
    set_addr(CYCLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h64) begin errors++; $display("FAIL cyc_load got %h want 00000064", dmem.data_mem_read_data); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dmem.data_mem_read_data !== 32'h67) begin errors++; $display("FAIL cyc_plus3 got %h want 00000067", dmem.data_mem_read_data); end
    do_store(CYCLE_A, 32'hFFFF_FFFF);
    set_addr(CYCLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_max got %h want ffffffff", dmem.data_mem_read_data); end
    @(negedge clk);
    #1;
    checks++; if (dmem.data_mem_read_data !== 32'h0) begin errors++; $display("FAIL cyc_wrap got %h want 00000000", dmem.data_mem_read_data); end
`else
    do_store(CYCLE_A, 32'h64);
    set_addr(CYCLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0) begin errors++; $display("FAIL cyc_off_load got %h want 0", dmem.data_mem_read_data); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dmem.data_mem_read_data !== 32'h0) begin errors++; $display("FAIL cyc_off_later got %h want 0", dmem.data_mem_read_data); end
`endif
  endtask

  task automatic test_halt();
    logic [31:0] exp_cyc;
`ifdef DMEM_CYCLE_COUNTER_EN
    exp_cyc = 32'h1001;
`else
    exp_cyc = 32'h0;
`endif
    console_ready = 1'b0;
    do_store(32'h0, 32'hA5A5A5A5);
    do_store(CONSOLE_A, 32'h77);
    do_store(CONSOLE_A, 32'h78);
    do_store(CYCLE_A, 32'h1000);
    do_store(TOHOST_A, 32'h1);
    #1;
    checks++; if (halt !== 1'b1 || tohost_value !== 32'h1) begin errors++; $display("FAIL halt_set got h=%0b t=%h want h=1 t=00000001", halt, tohost_value); end
    set_addr(TOHOST_A);
    checks++; if (dmem.data_mem_read_data !== 32'h1) begin errors++; $display("FAIL halt_tohost_rd got %h want 00000001", dmem.data_mem_read_data); end
    do_store(32'h0, 32'h0000_0BAD);
    set_addr(32'h0);
    checks++; if (dmem.data_mem_read_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL halt_ram_frozen got %h want a5a5a5a5", dmem.data_mem_read_data); end
    do_store(TOHOST_A, 32'h2);
    #1;
    checks++; if (tohost_value !== 32'h1) begin errors++; $display("FAIL halt_tohost_frozen got %h want 00000001", tohost_value); end
    set_addr(CYCLE_A);
    checks++; if (dmem.data_mem_read_data !== exp_cyc) begin errors++; $display("FAIL halt_cycle got %h want %h", dmem.data_mem_read_data, exp_cyc); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dmem.data_mem_read_data !== exp_cyc) begin errors++; $display("FAIL halt_cycle_later got %h want %h", dmem.data_mem_read_data, exp_cyc); end
    do_store(CONSOLE_A, 32'h99);
    console_ready = 1'b1;
    #1;
    checks++; if (console_valid !== 1'b1 || console_data !== 8'h77) begin errors++; $display("FAIL halt_drain0 got v=%0b d=%h want v=1 d=77", console_valid, console_data); end
    @(negedge clk);
    console_ready = 1'b0;
    #1;
    checks++; if (console_valid !== 1'b1 || console_data !== 8'h78) begin errors++; $display("FAIL halt_drain1 got v=%0b d=%h want v=1 d=78", console_valid, console_data); end
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0100) begin errors++; $display("FAIL halt_status got %h want 00000100", dmem.data_mem_read_data); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (halt !== 1'b0 || console_valid !== 1'b0 || tohost_value !== 32'h0) begin errors++; $display("FAIL rmid_state got h=%0b v=%0b t=%h want h=0 v=0 t=0", halt, console_valid, tohost_value); end
    set_addr(CONSOLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0000_0001) begin errors++; $display("FAIL rmid_status got %h want 00000001", dmem.data_mem_read_data); end
    set_addr(CYCLE_A);
    checks++; if (dmem.data_mem_read_data !== 32'h0) begin errors++; $display("FAIL rmid_cycle got %h want 0", dmem.data_mem_read_data); end
    @(negedge clk);
    reset = 1'b1;
    dmem.data_mem_write_enable = 1'b1;
    dmem.data_mem_addr = 32'h20;
    dmem.data_mem_write_data = 32'h0000_CAFE;
    @(negedge clk);
    reset = 1'b0;
    dmem.data_mem_write_enable = 1'b0;
    set_addr(32'h20);
    checks++; if (dmem.data_mem_read_data !== 32'h11111111) begin errors++; $display("FAIL rmid_store_dropped got %h want 11111111", dmem.data_mem_read_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    dmem.data_mem_write_enable = 1'b0;
    dmem.data_mem_addr = '0;
    dmem.data_mem_write_data = '0;
    @(negedge clk);
    test_reset();
    test_ram();
    test_console();
    test_overflow();
    test_full_push_pop();
    test_cycle();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
